// File: rtl/projectile_pool_if.sv
// Bundle between the projectile pool and its neighbours: launch controls in,
// per-slot positions and pool status out. i_/o_ are from the pool's point of view.
interface projectile_pool_if #(
    parameter int NUM_SLOTS = 4
);
    logic [9:0]             i_origin_x;
    logic [9:0]             i_origin_y;
    logic                   i_shoot;
    logic [1:0]             i_direction;
    logic [NUM_SLOTS-1:0]   i_kill;
    logic [NUM_SLOTS-1:0]   o_active;
    logic [10*NUM_SLOTS-1:0] o_bullet_x;
    logic [10*NUM_SLOTS-1:0] o_bullet_y;
    logic                   o_fire_accepted;
    logic                   o_full;

    modport slave (
        input  i_origin_x, i_origin_y, i_shoot, i_direction, i_kill,
        output o_active, o_bullet_x, o_bullet_y, o_fire_accepted, o_full
    );

    modport master (
        output i_origin_x, i_origin_y, i_shoot, i_direction, i_kill,
        input  o_active, o_bullet_x, o_bullet_y, o_fire_accepted, o_full
    );
endinterface

// File: rtl/projectile_pool.sv
// Pool of NUM_SLOTS projectiles with gravity, edge/kill retirement, lowest-free-slot
// launch on a shoot rising edge and a fire cooldown. Advances once per frame clock.
module projectile_pool #(
    parameter int NUM_SLOTS = 4,
    parameter int X_STEP    = 5,
    parameter int UP_SPEED  = 8,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 8,
    parameter int SIZE      = 3,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int COOLDOWN  = 8
) (
    input  logic clk,
    input  logic rst,
    projectile_pool_if.slave bus
);
    typedef enum logic {S_IDLE, S_FLIGHT} slot_state_t;

    localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam int SW = (NUM_SLOTS < 2) ? 1 : $clog2(NUM_SLOTS);

    localparam logic signed [11:0] SIZE_S  = 12'(SIZE);
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);
    localparam logic signed [8:0]  GRAV_S  = 9'(GRAVITY);
    localparam logic signed [8:0]  MAXF_S  = 9'(MAX_FALL);
    localparam logic signed [7:0]  VX_NEG  = 8'(-X_STEP);
    localparam logic signed [7:0]  VX_POS  = 8'(X_STEP);
    localparam logic signed [7:0]  VY_UP   = 8'(-UP_SPEED);

    logic [NUM_SLOTS-1:0] w_active;
    logic                 r_shoot_q;
    logic                 r_armed;
    logic [CW-1:0]        r_cooldown;
    logic                 r_fire_accepted;
    logic                 w_fire_req;
    logic                 w_launch;
    logic [SW-1:0]        w_alloc_idx;
    logic signed [7:0]    w_launch_vx;
    logic signed [7:0]    w_launch_vy;

    // Lowest-index idle slot wins; loop runs downward so the lowest index is assigned last.
    always_comb begin
        w_alloc_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!w_active[i]) begin
                w_alloc_idx = SW'(i);
            end
        end
    end

    // r_armed blocks a shoot held high across reset until a low sample is seen.
    assign w_fire_req = bus.i_shoot & ~r_shoot_q & r_armed;
    assign w_launch   = w_fire_req && (r_cooldown == '0) && !(&w_active);

    always_comb begin
        w_launch_vx = '0;
        w_launch_vy = '0;
        case (bus.i_direction)
            2'b00:   w_launch_vx = VX_NEG;
            2'b01:   w_launch_vx = VX_POS;
            2'b10:   w_launch_vy = VY_UP;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shoot_q       <= 1'b0;
            r_armed         <= 1'b0;
            r_cooldown      <= '0;
            r_fire_accepted <= 1'b0;
        end else begin
            r_shoot_q       <= bus.i_shoot;
            r_armed         <= r_armed | ~bus.i_shoot;
            r_fire_accepted <= w_launch;
            if (w_launch) begin
                r_cooldown <= CW'(COOLDOWN);
            end else if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        slot_state_t       r_state;
        slot_state_t       w_state_next;
        logic [9:0]        r_x, r_y, w_x_next, w_y_next;
        logic signed [7:0] r_vx, r_vy, w_vx_next, w_vy_next, w_vy_sat;
        logic signed [11:0] w_nx, w_ny;
        logic signed [8:0] w_vy_inc;
        logic              w_retire;
        logic              w_take;

        assign w_nx = $signed({2'b00, r_x}) + $signed({{4{r_vx[7]}}, r_vx});
        assign w_ny = $signed({2'b00, r_y}) + $signed({{4{r_vy[7]}}, r_vy});

        assign w_vy_inc = $signed({r_vy[7], r_vy}) + GRAV_S;
        assign w_vy_sat = (w_vy_inc > MAXF_S) ? MAXF_S[7:0] : w_vy_inc[7:0];

        assign w_retire = ((w_nx - SIZE_S) <= 12'sd0) || ((w_nx + SIZE_S) >= X_MAX_S) ||
                          ((w_ny - SIZE_S) <= 12'sd0) || ((w_ny + SIZE_S) >= Y_MAX_S) ||
                          bus.i_kill[gi];
        assign w_take   = w_launch && (w_alloc_idx == SW'(gi));

        // Idle values (origin, zero velocity) are the default; launch and flight override.
        always_comb begin
            w_state_next = r_state;
            w_x_next     = bus.i_origin_x;
            w_y_next     = bus.i_origin_y;
            w_vx_next    = '0;
            w_vy_next    = '0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        w_state_next = S_FLIGHT;
                        w_vx_next    = w_launch_vx;
                        w_vy_next    = w_launch_vy;
                    end
                end
                S_FLIGHT: begin
                    if (w_retire) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_x_next  = w_nx[9:0];
                        w_y_next  = w_ny[9:0];
                        w_vx_next = r_vx;
                        w_vy_next = w_vy_sat;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_x     <= '0;
                r_y     <= '0;
                r_vx    <= '0;
                r_vy    <= '0;
            end else begin
                r_state <= w_state_next;
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_vx    <= w_vx_next;
                r_vy    <= w_vy_next;
            end
        end

        assign w_active[gi]                = (r_state == S_FLIGHT);
        assign bus.o_bullet_x[gi*10 +: 10] = r_x;
        assign bus.o_bullet_y[gi*10 +: 10] = r_y;
    end

    assign bus.o_active        = w_active;
    assign bus.o_full          = &w_active;
    assign bus.o_fire_accepted = r_fire_accepted;
endmodule

// File: tb/tb_projectile_pool.sv
// Directed scenarios plus randomized traffic, checked every frame against an
// integer-arithmetic model of the projectile pool.
module tb_projectile_pool;
    localparam int NS = 4, XS = 5, UPS = 8, GR = 1, MF = 8, SZ = 3;
    localparam int XM = 639, YM = 479, CD = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    projectile_pool_if #(.NUM_SLOTS(NS)) bus ();

    projectile_pool #(
        .NUM_SLOTS(NS), .X_STEP(XS), .UP_SPEED(UPS), .GRAVITY(GR), .MAX_FALL(MF),
        .SIZE(SZ), .X_MAX(XM), .Y_MAX(YM), .COOLDOWN(CD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    int mx[NS], my[NS], mvx[NS], mvy[NS];
    bit mact[NS];
    int mcd;
    bit msq, marmed, mfa;

    int right_x[4] = '{325, 330, 335, 340};
    int right_y[4] = '{240, 241, 243, 246};
    int up_y[4]    = '{232, 225, 219, 214};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int bx(input int i);
        return int'(bus.o_bullet_x[i*10 +: 10]);
    endfunction

    function automatic int by(input int i);
        return int'(bus.o_bullet_y[i*10 +: 10]);
    endfunction

    function automatic int act_vec();
        return int'(bus.o_active);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            mact[i] = 1'b0; mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0;
        end
        mcd = 0; msq = 1'b0; marmed = 1'b0; mfa = 1'b0;
    endtask

    // One frame of the pool, from pre-edge model state and the current inputs.
    task automatic model_step();
        int sel, nx, ny, ox, oy, dir;
        bit launch;
        ox  = int'(bus.i_origin_x);
        oy  = int'(bus.i_origin_y);
        dir = int'(bus.i_direction);
        sel = -1;
        for (int i = NS - 1; i >= 0; i--) if (!mact[i]) sel = i;
        launch = bus.i_shoot && !msq && marmed && (mcd == 0) && (sel >= 0);
        for (int i = 0; i < NS; i++) begin
            if (mact[i]) begin
                nx = mx[i] + mvx[i];
                ny = my[i] + mvy[i];
                if (nx - SZ <= 0 || nx + SZ >= XM || ny - SZ <= 0 || ny + SZ >= YM || bus.i_kill[i]) begin
                    mact[i] = 1'b0; mx[i] = ox; my[i] = oy; mvx[i] = 0; mvy[i] = 0;
                end else begin
                    mx[i] = nx; my[i] = ny;
                    mvy[i] = (mvy[i] + GR > MF) ? MF : mvy[i] + GR;
                end
            end else if (launch && i == sel) begin
                mact[i] = 1'b1; mx[i] = ox; my[i] = oy;
                mvx[i] = (dir == 0) ? -XS : (dir == 1) ? XS : 0;
                mvy[i] = (dir == 2) ? -UPS : 0;
            end else begin
                mx[i] = ox; my[i] = oy; mvx[i] = 0; mvy[i] = 0;
            end
        end
        mcd    = launch ? CD : ((mcd > 0) ? mcd - 1 : 0);
        mfa    = launch;
        marmed = marmed || !bus.i_shoot;
        msq    = bus.i_shoot;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            bit all_act;
            all_act = 1'b1;
            for (int i = 0; i < NS; i++) begin
                chk($sformatf("model active[%0d]", i), int'(bus.o_active[i]), int'(mact[i]));
                chk($sformatf("model x[%0d]", i), bx(i), mx[i]);
                chk($sformatf("model y[%0d]", i), by(i), my[i]);
                all_act = all_act & mact[i];
            end
            chk("model fire_accepted", int'(bus.o_fire_accepted), int'(mfa));
            chk("model full", int'(bus.o_full), int'(all_act));
        end
    end

    initial begin
        bus.i_origin_x  = 10'd320;
        bus.i_origin_y  = 10'd240;
        bus.i_shoot     = 1'b0;
        bus.i_direction = 2'b01;
        bus.i_kill      = '0;
        #1 rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset active", act_vec(), 0);
        chk("reset x0", bx(0), 0);
        chk("reset y0", by(0), 0);
        chk("reset fire_accepted", int'(bus.o_fire_accepted), 0);
        chk("reset full", int'(bus.o_full), 0);
        run_cmp = 1'b1;

        tick();
        chk("idle tracks x", bx(0), 320);
        chk("idle tracks y", by(0), 240);

        // Right shot
        bus.i_shoot = 1'b1;
        tick();
        chk("right launch fa", int'(bus.o_fire_accepted), 1);
        chk("right launch active", act_vec(), 1);
        chk("right launch x", bx(0), 320);
        chk("right launch y", by(0), 240);
        bus.i_shoot = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("right step%0d x", k), bx(0), right_x[k]);
            chk($sformatf("right step%0d y", k), by(0), right_y[k]);
            chk($sformatf("right step%0d fa", k), int'(bus.o_fire_accepted), 0);
        end
        bus.i_kill = 4'b0001;
        tick();
        bus.i_kill = '0;
        chk("right killed", act_vec(), 0);
        ticks(10);

        // Up shot
        bus.i_direction = 2'b10;
        bus.i_shoot = 1'b1;
        tick();
        chk("up launch y", by(0), 240);
        bus.i_shoot = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("up step%0d y", k), by(0), up_y[k]);
        end
        bus.i_kill = 4'b0001;
        tick();
        bus.i_kill = '0;
        ticks(10);

        // Right-edge retire
        bus.i_origin_x  = 10'd630;
        bus.i_direction = 2'b01;
        bus.i_shoot = 1'b1;
        tick();
        chk("edge launch x", bx(0), 630);
        bus.i_shoot = 1'b0;
        tick();
        chk("edge step1 x", bx(0), 635);
        chk("edge step1 active", act_vec(), 1);
        tick();
        chk("edge retire active", act_vec(), 0);
        chk("edge retire x", bx(0), 630);
        ticks(10);

        // Pool fill: four accepted, two dropped while full
        bus.i_origin_x = 10'd20;
        bus.i_origin_y = 10'd100;
        for (int p = 0; p < 6; p++) begin
            bus.i_shoot = 1'b1;
            tick();
            chk($sformatf("pool p%0d fa", p), int'(bus.o_fire_accepted), (p < 4) ? 1 : 0);
            chk($sformatf("pool p%0d active", p), act_vec(), (p < 4) ? ((1 << (p + 1)) - 1) : 15);
            chk($sformatf("pool p%0d full", p), int'(bus.o_full), (p >= 3) ? 1 : 0);
            bus.i_shoot = 1'b0;
            ticks(9);
        end
        bus.i_kill = 4'b1111;
        tick();
        bus.i_kill = '0;
        chk("pool cleared", act_vec(), 0);
        ticks(10);

        // Kill / reuse / cooldown
        bus.i_shoot = 1'b1; tick(); bus.i_shoot = 1'b0; ticks(9);
        bus.i_shoot = 1'b1; tick();
        chk("reuse second fire active", act_vec(), 3);
        bus.i_shoot = 1'b0; ticks(2);
        bus.i_shoot = 1'b1; tick();
        chk("cooldown drop fa", int'(bus.o_fire_accepted), 0);
        chk("cooldown drop active", act_vec(), 3);
        bus.i_shoot = 1'b0;
        bus.i_kill = 4'b0001;
        tick();
        bus.i_kill = '0;
        chk("kill slot0", act_vec(), 2);
        ticks(4);
        bus.i_shoot = 1'b1; tick();
        chk("cooldown untouched fa", int'(bus.o_fire_accepted), 1);
        chk("reuse slot0 active", act_vec(), 3);
        chk("reuse slot0 x", bx(0), 20);
        bus.i_shoot = 1'b0; ticks(9);
        bus.i_shoot = 1'b1; tick(); bus.i_shoot = 1'b0; ticks(9);
        bus.i_shoot = 1'b1; tick();
        chk("refill full", int'(bus.o_full), 1);
        bus.i_shoot = 1'b0; ticks(9);
        bus.i_shoot = 1'b1;
        bus.i_kill = 4'b0001;
        tick();
        chk("kill+fire full fa", int'(bus.o_fire_accepted), 0);
        chk("kill+fire full active", act_vec(), 14);
        bus.i_shoot = 1'b0;
        bus.i_kill = '0;
        tick();
        bus.i_shoot = 1'b1;
        tick();
        chk("after kill fire fa", int'(bus.o_fire_accepted), 1);
        chk("after kill fire active", act_vec(), 15);

        // Asynchronous reset between edges, shoot held high
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async rst active", act_vec(), 0);
        chk("async rst fa", int'(bus.o_fire_accepted), 0);
        chk("async rst x0", bx(0), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("held shoot no fire 1", int'(bus.o_fire_accepted), 0);
        chk("held shoot active", act_vec(), 0);
        tick();
        chk("held shoot no fire 2", int'(bus.o_fire_accepted), 0);
        bus.i_shoot = 1'b0;
        tick();
        bus.i_shoot = 1'b1;
        tick();
        chk("refire after low fa", int'(bus.o_fire_accepted), 1);
        chk("refire after low active", act_vec(), 1);
        bus.i_shoot = 1'b0;

        // Randomized traffic, checked by the model every frame
        for (int n = 0; n < 3000; n++) begin
            bus.i_shoot     = ($urandom_range(0, 2) == 0);
            bus.i_direction = 2'($urandom_range(0, 3));
            bus.i_origin_x  = 10'($urandom_range(0, 639));
            bus.i_origin_y  = 10'($urandom_range(0, 479));
            bus.i_kill      = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
            tick();
        end

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/projectile_pool.md
# projectile_pool

Multi-slot projectile engine: the parametrised successor to the single-bullet block. It holds NUM_SLOTS independent projectiles, each with horizontal motion and saturating gravity. It launches into the lowest free slot on a rising edge of `shoot`, enforces a fire cooldown, and retires slots at screen edges or on an external kill. It sits between the player/ball motion logic (origin, direction, fire) and the collision and colour mappers (per-slot positions, active flags), and advances once per frame.

## Interface
- NUM_SLOTS, 4: number of concurrent projectiles (1..8)
- X_STEP, 5: horizontal speed, px/frame, for directions 00/01
- UP_SPEED, 8: initial upward speed, px/frame, for direction 10
- GRAVITY, 1: vy increment per frame
- MAX_FALL, 8: positive vy saturation limit
- SIZE, 3: projectile half-size, used for edge tests
- X_MAX, 639 / Y_MAX, 479: screen bounds; min bound is 0 on both axes
- COOLDOWN, 8: frames after an accepted fire during which fire requests are ignored

- frame_clk  in  1  frame-rate clock; all state updates on its posedge
- Reset  in  1  asynchronous, active-high reset
- OriginX, OriginY  in  10 each  launch origin (ball centre), unsigned pixels
- shoot  in  1  fire request, level; only the 0→1 transition counts
- Direction  in  2  00 left, 01 right, 10 up, 11 drop
- kill  in  NUM_SLOTS  per-slot retire request from collision logic
- active  out  NUM_SLOTS  slot i in flight
- BulletX, BulletY  out  10*NUM_SLOTS each  slot i occupies bits [10i+9:10i]
- fire_accepted  out  1  one-frame pulse: a launch happened on this edge
- full  out  1  all slots active

## Operation
- Each slot has 2 states, IDLE and FLIGHT. It holds registers x, y (10b unsigned), vx, vy (8b signed).
- IDLE: x,y load OriginX/OriginY every frame (carried with the ball); vx=vy=0.
- Fire request: shoot=1 and shoot_q=0, where shoot_q is the registered shoot. The request is accepted only if cooldown counter == 0 and at least one slot is IDLE (pre-edge state).
- Launch: the lowest-index IDLE slot goes to FLIGHT. x,y ← Origin. vx/vy per Direction: 00 → (−X_STEP, 0); 01 → (+X_STEP, 0); 10 → (0, −UP_SPEED); 11 → (0, 0).
- On launch: fire_accepted=1 and cooldown ← COOLDOWN. Otherwise cooldown decrements to 0 and saturates there.
- Rejected requests (cooldown ≠ 0 or full) are dropped, not queued, and do not touch cooldown.
- FLIGHT update per frame: nx = x+vx and ny = y+vy, computed 11b signed. vy ← min(vy+GRAVITY, MAX_FALL).
- Retire to IDLE if any of: nx−SIZE ≤ 0, nx+SIZE ≥ X_MAX, ny−SIZE ≤ 0, ny+SIZE ≥ Y_MAX, or kill[i]. On retire, the slot takes IDLE values on the same edge (Origin, zero velocity).
- Otherwise x←nx[9:0] and y←ny[9:0].
- kill[i] while slot i is IDLE: no effect.
- full = &active, combinational from registered state.

## Timing
- Reset, any time, async: all slots IDLE, x,y=0 until the first edge after release, vx=vy=0, active=0, fire_accepted=0, cooldown=0, shoot_q=0, full=0.
- Launch latency: shoot rises before edge k → active[i]=1 and position=Origin after edge k. First motion after edge k+1.
- Per-edge order: allocation and retire decisions use pre-edge state. A slot retiring on edge k is not allocatable until edge k+1.
- Simultaneous launch and kill on different slots: both happen.
- Gravity applies after position: the launch frame uses the launch vy, and the increment is visible from the next step.
- Holding shoot high fires once. Re-fire needs a 0 sample.
- Reset mid-flight clears every slot immediately, without waiting for frame_clk.

## Test plan
- Right shot: Origin (320,240), Dir=01, defaults. After launch edge (320,240). Subsequent edges (325,240), (330,241), (335,243), (340,246). fire_accepted high only on the launch edge.
- Up shot: Origin (320,240), Dir=10. Y sequence 240, 232, 225, 219, 214. Apex reached, then falling; vy saturates at 8.
- Edge retire: Origin (630,240), Dir=01. Edge1 x=635, active=1. Edge2 nx=640 → active=0, x tracks Origin.
- Pool and cooldown: 6 shoot pulses spaced 10 frames apart, slots not retiring. Slots 0–3 fill, full=1, pulses 5–6 dropped. A pulse 3 frames after an accepted fire is dropped with cooldown unchanged.
- Kill/reuse: slots 0,1 active, kill=0001 → slot 0 IDLE next edge. The next accepted fire goes to slot 0. Kill and fire on the same edge with pool full → fire rejected.
- Async reset: assert Reset mid-flight between edges. active=0 and fire_accepted=0 immediately. After release, a held-high shoot does not fire until shoot goes low and then high again.
